// File: rtl/next_pc_resolver.sv
// next_pc_resolver: picks the next fetch PC each cycle from the resolved branch
// outcome, the prediction carried with it, and the live predictor. A mispredict
// redirects fetch and holds flush_pipeline for FLUSH_CYCLES cycles, during which
// no new decisions are taken. Saturating counters track resolved branches and
// mispredicts.
//
// state | meaning
// IDLE  | accepting decisions every cycle
// FLUSH | flush in progress, decision inputs ignored, fcnt counts down to 0
module next_pc_resolver #(
    parameter int XLEN         = 32,
    parameter int INST_BYTES   = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             resolve_valid,
    input  logic             branch_result,
    input  logic             prev_branch_prediction,
    input  logic [XLEN-1:0]  prev_pc,
    input  logic [XLEN-1:0]  pc_add_build_target,
    input  logic             branch_prediction_actual,
    input  logic [XLEN-1:0]  pc_target_prediction_actual,
    input  logic             clear_stats,
    output logic [XLEN-1:0]  pc_new,
    output logic             take_new_pc,
    output logic             flush_pipeline,
    output logic             redirect_busy,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // fcnt is loaded with FLUSH_CYCLES-1 so that the flush window, which
    // includes the redirect cycle itself, is exactly FLUSH_CYCLES long.
    localparam logic [3:0]       FCNT_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [XLEN-1:0]  PC_INC    = XLEN'(INST_BYTES);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic [XLEN-1:0]  pc_new_q, pc_new_d;
    logic             take_q, take_d;
    logic             flush_q, flush_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic             mispredict;

    assign mispredict = resolve_valid & (branch_result != prev_branch_prediction);

    // Next-state, decision and statistics logic.
    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        pc_new_d = pc_new_q;
        take_d   = 1'b0;
        flush_d  = 1'b0;
        bcnt_d   = bcnt_q;
        mcnt_d   = mcnt_q;

        unique case (state_q)
            IDLE: begin
                if (mispredict) begin
                    pc_new_d = branch_result ? pc_add_build_target : (prev_pc + PC_INC);
                    take_d   = 1'b1;
                    flush_d  = 1'b1;
                    state_d  = FLUSH;
                    fcnt_d   = FCNT_INIT;
                end else if (branch_prediction_actual) begin
                    pc_new_d = pc_target_prediction_actual;
                    take_d   = 1'b1;
                end

                if (resolve_valid && (bcnt_q != CNT_MAX)) begin
                    bcnt_d = bcnt_q + 1'b1;
                end
                if (mispredict && (mcnt_q != CNT_MAX)) begin
                    mcnt_d = mcnt_q + 1'b1;
                end
            end
            FLUSH: begin
                if (fcnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    fcnt_d  = fcnt_q - 1'b1;
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clearing the statistics overrides any increment in the same cycle.
        if (clear_stats) begin
            bcnt_d = '0;
            mcnt_d = '0;
        end
    end

    // State, decision outputs and counters, asynchronously reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            fcnt_q   <= 4'd0;
            pc_new_q <= '0;
            take_q   <= 1'b0;
            flush_q  <= 1'b0;
            bcnt_q   <= '0;
            mcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            pc_new_q <= pc_new_d;
            take_q   <= take_d;
            flush_q  <= flush_d;
            bcnt_q   <= bcnt_d;
            mcnt_q   <= mcnt_d;
        end
    end

    assign pc_new           = pc_new_q;
    assign take_new_pc      = take_q;
    assign flush_pipeline   = flush_q;
    assign redirect_busy    = (state_q == FLUSH);
    assign branch_count     = bcnt_q;
    assign mispredict_count = mcnt_q;

endmodule

// File: tb/tb_next_pc_resolver.sv
// Directed bench for next_pc_resolver. Instance a uses FLUSH_CYCLES=2 and
// 4-bit counters; instance b uses FLUSH_CYCLES=3 and 16-bit counters and is
// checked in the reset-during-flush scenario. Both share all inputs.
module tb_next_pc_resolver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        resolve_valid;
    logic        branch_result;
    logic        prev_branch_prediction;
    logic [31:0] prev_pc;
    logic [31:0] pc_add_build_target;
    logic        branch_prediction_actual;
    logic [31:0] pc_target_prediction_actual;
    logic        clear_stats;

    logic [31:0] a_pc_new,  b_pc_new;
    logic        a_take,    b_take;
    logic        a_flush,   b_flush;
    logic        a_busy,    b_busy;
    logic [3:0]  a_bcnt,    a_mcnt;
    logic [15:0] b_bcnt,    b_mcnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    next_pc_resolver #(.XLEN(32), .INST_BYTES(4), .FLUSH_CYCLES(2), .CNT_W(4)) dut_a (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .resolve_valid               (resolve_valid),
        .branch_result               (branch_result),
        .prev_branch_prediction      (prev_branch_prediction),
        .prev_pc                     (prev_pc),
        .pc_add_build_target         (pc_add_build_target),
        .branch_prediction_actual    (branch_prediction_actual),
        .pc_target_prediction_actual (pc_target_prediction_actual),
        .clear_stats                 (clear_stats),
        .pc_new                      (a_pc_new),
        .take_new_pc                 (a_take),
        .flush_pipeline              (a_flush),
        .redirect_busy               (a_busy),
        .branch_count                (a_bcnt),
        .mispredict_count            (a_mcnt)
    );

    next_pc_resolver #(.XLEN(32), .INST_BYTES(4), .FLUSH_CYCLES(3), .CNT_W(16)) dut_b (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .resolve_valid               (resolve_valid),
        .branch_result               (branch_result),
        .prev_branch_prediction      (prev_branch_prediction),
        .prev_pc                     (prev_pc),
        .pc_add_build_target         (pc_add_build_target),
        .branch_prediction_actual    (branch_prediction_actual),
        .pc_target_prediction_actual (pc_target_prediction_actual),
        .clear_stats                 (clear_stats),
        .pc_new                      (b_pc_new),
        .take_new_pc                 (b_take),
        .flush_pipeline              (b_flush),
        .redirect_busy               (b_busy),
        .branch_count                (b_bcnt),
        .mispredict_count            (b_mcnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        resolve_valid               = 1'b0;
        branch_result               = 1'b0;
        prev_branch_prediction      = 1'b0;
        prev_pc                     = 32'h0;
        pc_add_build_target         = 32'h0;
        branch_prediction_actual    = 1'b0;
        pc_target_prediction_actual = 32'h0;
        clear_stats                 = 1'b0;
    endtask

    task automatic chk_a(input string tag, input logic [31:0] pc, input logic take,
                         input logic flush, input logic busy,
                         input logic [3:0] bc, input logic [3:0] mc);
        chk({tag, ".pc_new"}, 64'(a_pc_new), 64'(pc));
        chk({tag, ".take"},   64'(a_take),   64'(take));
        chk({tag, ".flush"},  64'(a_flush),  64'(flush));
        chk({tag, ".busy"},   64'(a_busy),   64'(busy));
        chk({tag, ".bcnt"},   64'(a_bcnt),   64'(bc));
        chk({tag, ".mcnt"},   64'(a_mcnt),   64'(mc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        chk_a("reset_a", 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        chk("reset_b.busy", 64'(b_busy), 64'd0);
        chk("reset_b.bcnt", 64'(b_bcnt), 64'd0);
        rst_n = 1'b1;
        tick();
        chk_a("idle_a", 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

        // Missed taken branch -> redirect to target, 2-cycle flush.
        resolve_valid          = 1'b1;
        branch_result          = 1'b1;
        prev_branch_prediction = 1'b0;
        prev_pc                = 32'h0000_1000;
        pc_add_build_target    = 32'h0000_2000;
        tick();
        chk_a("taken_t1", 32'h2000, 1'b1, 1'b1, 1'b1, 4'd1, 4'd1);
        idle_inputs();
        tick();
        chk_a("taken_t2", 32'h2000, 1'b0, 1'b1, 1'b1, 4'd1, 4'd1);
        tick();
        chk_a("taken_t3", 32'h2000, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1);

        // Wrongly taken at the top of memory -> fall-through wraps to 0.
        resolve_valid          = 1'b1;
        branch_result          = 1'b0;
        prev_branch_prediction = 1'b1;
        prev_pc                = 32'hFFFF_FFFC;
        tick();
        chk_a("wrap_t1", 32'h0, 1'b1, 1'b1, 1'b1, 4'd2, 4'd2);
        // Another mispredict inside the flush window must be ignored.
        branch_result          = 1'b1;
        prev_branch_prediction = 1'b0;
        pc_add_build_target    = 32'h0000_3000;
        tick();
        chk_a("wrap_inflush", 32'h0, 1'b0, 1'b1, 1'b1, 4'd2, 4'd2);
        idle_inputs();
        tick();
        chk_a("wrap_t3", 32'h0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd2);

        // Back-to-back predictor follows.
        branch_prediction_actual    = 1'b1;
        pc_target_prediction_actual = 32'h100;
        tick();
        chk_a("follow1", 32'h100, 1'b1, 1'b0, 1'b0, 4'd2, 4'd2);
        pc_target_prediction_actual = 32'h200;
        tick();
        chk_a("follow2", 32'h200, 1'b1, 1'b0, 1'b0, 4'd2, 4'd2);
        branch_prediction_actual = 1'b0;
        tick();
        chk_a("fallthru_hold", 32'h200, 1'b0, 1'b0, 1'b0, 4'd2, 4'd2);

        // Mispredict and live prediction together: mispredict wins.
        resolve_valid               = 1'b1;
        branch_result               = 1'b1;
        prev_branch_prediction      = 1'b0;
        pc_add_build_target         = 32'h40;
        branch_prediction_actual    = 1'b1;
        pc_target_prediction_actual = 32'h80;
        tick();
        chk_a("simul_t1", 32'h40, 1'b1, 1'b1, 1'b1, 4'd3, 4'd3);
        idle_inputs();
        tick();
        tick();
        chk_a("simul_done", 32'h40, 1'b0, 1'b0, 1'b0, 4'd3, 4'd3);

        // Correctly predicted resolution counts a branch, no redirect.
        resolve_valid          = 1'b1;
        branch_result          = 1'b1;
        prev_branch_prediction = 1'b1;
        tick();
        chk_a("correct", 32'h40, 1'b0, 1'b0, 1'b0, 4'd4, 4'd3);

        // 20 more correct resolutions saturate the 4-bit branch counter.
        branch_result          = 1'b0;
        prev_branch_prediction = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk_a("saturate", 32'h40, 1'b0, 1'b0, 1'b0, 4'd15, 4'd3);

        // Clear wins over a same-cycle increment.
        clear_stats = 1'b1;
        tick();
        chk_a("clear", 32'h40, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        idle_inputs();
        tick();

        // Reset during the second flush cycle of the FLUSH_CYCLES=3 instance.
        resolve_valid          = 1'b1;
        branch_result          = 1'b1;
        prev_branch_prediction = 1'b0;
        pc_add_build_target    = 32'h5000;
        tick();
        chk("rst_b_t1.pc_new", 64'(b_pc_new), 64'h5000);
        chk("rst_b_t1.flush",  64'(b_flush),  64'd1);
        chk("rst_b_t1.bcnt",   64'(b_bcnt),   64'd1);
        idle_inputs();
        tick();
        chk("rst_b_t2.flush", 64'(b_flush), 64'd1);
        chk("rst_b_t2.busy",  64'(b_busy),  64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_b_async.pc_new", 64'(b_pc_new), 64'd0);
        chk("rst_b_async.take",   64'(b_take),   64'd0);
        chk("rst_b_async.flush",  64'(b_flush),  64'd0);
        chk("rst_b_async.busy",   64'(b_busy),   64'd0);
        chk("rst_b_async.bcnt",   64'(b_bcnt),   64'd0);
        chk("rst_b_async.mcnt",   64'(b_mcnt),   64'd0);
        chk_a("rst_a_async", 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        tick();
        rst_n = 1'b1;

        // After release the instance is back in IDLE and follows at once.
        branch_prediction_actual    = 1'b1;
        pc_target_prediction_actual = 32'h300;
        tick();
        chk("post_rst_b.pc_new", 64'(b_pc_new), 64'h300);
        chk("post_rst_b.take",   64'(b_take),   64'd1);
        chk("post_rst_b.flush",  64'(b_flush),  64'd0);
        chk("post_rst_b.busy",   64'(b_busy),   64'd0);
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/next_pc_resolver.md
# next_pc_resolver

Registered, parametrised next-PC decision unit with multi-cycle flush sequencing and branch statistics. Sits between branch resolution in execute, the branch predictor and the fetch PC register. Each cycle it compares the prediction carried down the pipeline with the resolved outcome and picks one of three actions: redirect fetch on a mispredict, follow the live predictor, or fall through. A mispredict holds `flush_pipeline` for a programmable number of cycles while new decisions are blocked, and saturating counters track resolved branches and mispredicts.

## Interface
- `XLEN`, 32, width of all PC buses.
- `INST_BYTES`, 4, fall-through increment added to `prev_pc`.
- `FLUSH_CYCLES`, 2, cycles `flush_pipeline` stays high per mispredict; legal range 1..15.
- `CNT_W`, 16, width of the statistics counters.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `resolve_valid`  in  1  a branch resolves this cycle.
- `branch_result`  in  1  resolved outcome; 1 = taken.
- `prev_branch_prediction`  in  1  prediction carried with the resolving branch; 1 = predicted taken.
- `prev_pc`  in  XLEN  PC of the resolving branch.
- `pc_add_build_target`  in  XLEN  computed branch target from the address builder.
- `branch_prediction_actual`  in  1  live predictor decision for the current fetch.
- `pc_target_prediction_actual`  in  XLEN  live predictor target.
- `clear_stats`  in  1  synchronous clear of both counters.
- `pc_new`  out  XLEN  registered next PC.
- `take_new_pc`  out  1  registered; fetch loads `pc_new` this cycle.
- `flush_pipeline`  out  1  registered; squash younger instructions.
- `redirect_busy`  out  1  high while the FSM is in FLUSH.
- `branch_count`  out  CNT_W  resolved branches, saturating.
- `mispredict_count`  out  CNT_W  mispredicts, saturating.

## Operation
- FSM states are IDLE and FLUSH, plus a flush down-counter `fcnt` (4 bits).
- A mispredict is `resolve_valid & (branch_result != prev_branch_prediction)`.
- In IDLE, the first matching rule in this priority order wins:
  - Mispredict with `branch_result`=1: `pc_new`<=`pc_add_build_target`, `take_new_pc`<=1, `flush_pipeline`<=1, state<=FLUSH, `fcnt`<=FLUSH_CYCLES-1.
  - Mispredict with `branch_result`=0: `pc_new`<=`prev_pc`+INST_BYTES, truncated to XLEN (wraps modulo 2^XLEN). All other updates match the taken case.
  - No mispredict and `branch_prediction_actual`=1: `pc_new`<=`pc_target_prediction_actual`, `take_new_pc`<=1, `flush_pipeline`<=0.
  - Otherwise: `take_new_pc`<=0, `flush_pipeline`<=0, and `pc_new` keeps its value.
- In FLUSH, all decision inputs are ignored and no counter increments.
  - `take_new_pc`<=0 and `pc_new` holds.
  - If `fcnt`==0: state<=IDLE, `flush_pipeline`<=0.
  - Else: `fcnt` decrements and `flush_pipeline` stays 1.
- `redirect_busy` is combinational from state: 1 in FLUSH.
- Counters update only in IDLE.
  - `branch_count` increments on `resolve_valid`.
  - `mispredict_count` increments on a mispredict.
  - Both saturate at 2^CNT_W-1.
  - `clear_stats` zeroes both counters in any state and wins over a same-cycle increment.
- Reset (asynchronous, any state including mid-FLUSH): state IDLE, `fcnt`=0, `pc_new`=0, `take_new_pc`=0, `flush_pipeline`=0, both counters 0. `redirect_busy` is therefore 0.

## Timing
- Decision latency is one cycle: inputs sampled at the edge ending cycle T drive outputs during T+1.
- Mispredict sampled at end of T:
  - `take_new_pc`=1 only in T+1.
  - `flush_pipeline`=1 in T+1 through T+FLUSH_CYCLES.
  - `redirect_busy`=1 over the same window.
- The first post-flush sample is at the end of T+FLUSH_CYCLES+1; its result appears in T+FLUSH_CYCLES+2.
- A predictor-follow decision never raises `flush_pipeline` and imposes no dead cycles, so back-to-back follows are legal every cycle.
- When a mispredict and a live `branch_prediction_actual`=1 occur in the same cycle, the mispredict wins and the live prediction is discarded.
- Reset deassertion is synchronised externally; the first legal sample is at the first edge after release.

## Test plan
- Reset mid-FLUSH: XLEN=32, FLUSH_CYCLES=3. Mispredict, then assert `rst_n`=0 during the second flush cycle -> all outputs 0 immediately, both counters 0, state IDLE after release.
- Missed taken branch: `resolve_valid`=1, `branch_result`=1, `prev_branch_prediction`=0, `pc_add_build_target`=0x0000_2000 -> next cycle `pc_new`=0x2000 with `take_new_pc`=1. With FLUSH_CYCLES=2, `flush_pipeline`=1 for exactly 2 cycles, `mispredict_count`=1, `branch_count`=1.
- Wrongly taken with wrap: `branch_result`=0, `prev_branch_prediction`=1, `prev_pc`=0xFFFF_FFFC -> `pc_new`=0x0000_0000 and `take_new_pc`=1. A second mispredict presented during the flush produces no redirect and no count change.
- Predictor follow: `resolve_valid`=0, `branch_prediction_actual`=1, `pc_target_prediction_actual`=0x100, then 0x200 on the next cycle -> `pc_new` is 0x100 then 0x200, `take_new_pc` stays 1, `flush_pipeline` stays 0.
- Simultaneous mispredict and live prediction: mispredict with target 0x40 plus `branch_prediction_actual`=1 with target 0x80 -> `pc_new`=0x40 and `flush_pipeline`=1.
- Saturation and clear: CNT_W=4, 20 correct resolutions -> `branch_count`=15. Then `clear_stats` together with `resolve_valid` -> `branch_count`=0.
